// File: rtl/axi4_wr_master.sv
// ---------------------------------------------------------------------------
// axi4_wr_master
//   Single-beat AXI4 write master. A simple valid/ready store request
//   (address, data, byte strobes) is turned into one AW transfer and one W
//   transfer. The B response is handed back to the requester. Writes are
//   issued in order with a fixed AWID. Up to MAX_OUTSTANDING writes may be
//   waiting for their B response at any time.
//
// Ports
//   ACLK, ARESETn         clock, synchronous active-low reset
//   req_valid/req_ready   store request handshake
//   req_addr/data/strb    store payload, latched on accept
//   rsp_valid/rsp_ready   write response handshake (mirrors BVALID/BREADY)
//   rsp_err               BRESP[1] (SLVERR or DECERR)
//   busy                  writes outstanding or AW/W still pending
//   protocol_err          sticky: a B handshake arrived with nothing outstanding
//   AW*/W*/B*             AXI4 write address, write data, write response
// ---------------------------------------------------------------------------
module axi4_wr_master #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int ID_W            = 4,
    parameter int AXI_ID          = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [DATA_W/8-1:0] req_strb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_err,
    output logic                busy,
    output logic                protocol_err,

    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [ID_W-1:0]     AWID,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic [2:0]          AWPROT,

    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,

    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP,
    input  logic [ID_W-1:0]     BID
);

    localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] outstanding;
    logic             accept;
    logic             aw_done;
    logic             w_done;
    logic             b_done;

    // BID is not checked (single fixed ID) and EXOKAY has no meaning for
    // a non-exclusive write, so these bits are deliberately left unused.
    logic             unused_inputs;
    assign unused_inputs = ^{BID, BRESP[0]};

    // Constant AW/W fields: single beat, full-width INCR, unprivileged data.
    assign AWID    = ID_W'(AXI_ID);
    assign AWLEN   = 8'd0;
    assign AWSIZE  = 3'($clog2(DATA_W / 8));
    assign AWBURST = 2'b01;
    assign AWPROT  = 3'b000;
    assign WLAST   = 1'b1;

    // A new request may only be taken when both channel slots are free or
    // freeing up this very edge, so the payload registers are never
    // overwritten while a transfer is still being presented.
    assign req_ready = ARESETn
                    && (!AWVALID || AWREADY)
                    && (!WVALID  || WREADY)
                    && (outstanding < MAX_CNT);

    assign accept  = req_valid && req_ready;
    assign aw_done = AWVALID && AWREADY;
    assign w_done  = WVALID  && WREADY;

    assign BREADY    = ARESETn && rsp_ready;
    assign b_done    = BVALID && BREADY;
    assign rsp_valid = BVALID;
    assign rsp_err   = BRESP[1];

    assign busy = (outstanding != '0) || AWVALID || WVALID;

    // AW and W channel registers. A same-edge accept re-arms a channel that
    // is handshaking, so back-to-back writes need no bubble.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            AWVALID <= 1'b0;
            WVALID  <= 1'b0;
            AWADDR  <= '0;
            WDATA   <= '0;
            WSTRB   <= '0;
        end else if (accept) begin
            AWVALID <= 1'b1;
            WVALID  <= 1'b1;
            AWADDR  <= req_addr;
            WDATA   <= req_data;
            WSTRB   <= req_strb;
        end else begin
            if (aw_done) AWVALID <= 1'b0;
            if (w_done)  WVALID  <= 1'b0;
        end
    end

    // Outstanding write counter. A B handshake with nothing outstanding is
    // flagged and never allowed to wrap the counter.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            outstanding  <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (b_done && (outstanding == '0)) begin
                protocol_err <= 1'b1;
            end
            case ({accept, b_done})
                2'b10: outstanding <= outstanding + CNT_ONE;
                2'b01: if (outstanding != '0) outstanding <= outstanding - CNT_ONE;
                2'b11: if (outstanding == '0) outstanding <= outstanding + CNT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_wr_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_wr_master
//   Directed bench for axi4_wr_master with default parameters
//   (32-bit address/data, MAX_OUTSTANDING = 4). Inputs change on the falling
//   edge; outputs are sampled 1 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_axi4_wr_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic        busy;
    logic        protocol_err;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [3:0]  AWID;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [2:0]  AWPROT;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic [3:0]  BID;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc;

    always #5 ACLK = ~ACLK;

    axi4_wr_master dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_strb     (req_strb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .protocol_err (protocol_err),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .AWADDR       (AWADDR),
        .AWID         (AWID),
        .AWLEN        (AWLEN),
        .AWSIZE       (AWSIZE),
        .AWBURST      (AWBURST),
        .AWPROT       (AWPROT),
        .WVALID       (WVALID),
        .WREADY       (WREADY),
        .WDATA        (WDATA),
        .WSTRB        (WSTRB),
        .WLAST        (WLAST),
        .BVALID       (BVALID),
        .BREADY       (BREADY),
        .BRESP        (BRESP),
        .BID          (BID)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; the caller then drives inputs.
    task automatic step();
        @(negedge ACLK);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        ARESETn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '0;
        rsp_ready = 1'b1;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        BRESP     = 2'b00;
        BID       = '0;

        // ---------------- reset state ----------------
        step(); step(); settle();
        check("rst_awvalid",   64'(AWVALID), 64'd0);
        check("rst_wvalid",    64'(WVALID), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_bready",    64'(BREADY), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_perr",      64'(protocol_err), 64'd0);
        check("rst_awaddr",    64'(AWADDR), 64'd0);
        check("rst_wdata",     64'(WDATA), 64'd0);
        check("rst_wstrb",     64'(WSTRB), 64'd0);
        check("const_awid",    64'(AWID), 64'd0);
        check("const_awburst", 64'(AWBURST), 64'd1);
        check("const_awprot",  64'(AWPROT), 64'd0);

        ARESETn = 1'b1;
        settle();
        check("post_rst_ready", 64'(req_ready), 64'd1);

        // ---------------- single write, slave always ready ----------------
        AWREADY   = 1'b1;
        WREADY    = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_1000;
        req_data  = 32'hDEAD_BEEF;
        req_strb  = 4'hF;
        step();
        req_valid = 1'b0;
        settle();
        check("t1_awvalid", 64'(AWVALID), 64'd1);
        check("t1_wvalid",  64'(WVALID), 64'd1);
        check("t1_awaddr",  64'(AWADDR), 64'h1000);
        check("t1_wdata",   64'(WDATA), 64'hDEAD_BEEF);
        check("t1_wstrb",   64'(WSTRB), 64'hF);
        check("t1_awlen",   64'(AWLEN), 64'd0);
        check("t1_awsize",  64'(AWSIZE), 64'd2);
        check("t1_wlast",   64'(WLAST), 64'd1);
        step(); settle();
        check("t1_awvalid_drop", 64'(AWVALID), 64'd0);
        check("t1_wvalid_drop",  64'(WVALID), 64'd0);
        check("t1_busy_wait_b",  64'(busy), 64'd1);
        BVALID = 1'b1;
        BRESP  = 2'b00;
        settle();
        check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1_rsp_err",   64'(rsp_err), 64'd0);
        check("t1_bready",    64'(BREADY), 64'd1);
        step();
        BVALID = 1'b0;
        settle();
        check("t1_busy_idle", 64'(busy), 64'd0);
        check("t1_perr",      64'(protocol_err), 64'd0);

        // ---------------- AW stalled, W free ----------------
        AWREADY   = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_2000;
        req_data  = 32'h1122_3344;
        req_strb  = 4'h3;
        step();
        req_valid = 1'b0;
        settle();
        check("t2_awvalid", 64'(AWVALID), 64'd1);
        check("t2_wvalid",  64'(WVALID), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            req_valid = 1'b1;
            req_addr  = 32'h0000_9990;
            settle();
            check("t2_aw_hold",   64'(AWVALID), 64'd1);
            check("t2_addr_hold", 64'(AWADDR), 64'h2000);
            check("t2_ready_low", 64'(req_ready), 64'd0);
            if (i == 0) check("t2_w_done", 64'(WVALID), 64'd0);
        end
        req_valid = 1'b0;
        AWREADY   = 1'b1;
        settle();
        check("t2_ready_on_aw", 64'(req_ready), 64'd1);
        step(); settle();
        check("t2_aw_done", 64'(AWVALID), 64'd0);
        BVALID = 1'b1;
        BRESP  = 2'b10;
        settle();
        check("t2_rsp_err", 64'(rsp_err), 64'd1);
        step();
        BVALID = 1'b0;
        BRESP  = 2'b00;
        settle();
        check("t2_busy_idle", 64'(busy), 64'd0);

        // ---------------- outstanding limit ----------------
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h0000_3000 + 32'(n_acc * 16);
            settle();
            if (req_ready) n_acc++;
            step();
        end
        settle();
        check("t3_accepted",  64'(n_acc), 64'd4);
        check("t3_ready_low", 64'(req_ready), 64'd0);
        check("t3_last_addr", 64'(AWADDR), 64'h3030);
        req_addr = 32'h0000_3040;
        BVALID   = 1'b1;
        settle();
        check("t3_ready_during_b", 64'(req_ready), 64'd0);
        step();
        BVALID = 1'b0;
        settle();
        check("t3_ready_after_b", 64'(req_ready), 64'd1);
        step(); settle();
        check("t3_fifth_aw",   64'(AWVALID), 64'd1);
        check("t3_fifth_addr", 64'(AWADDR), 64'h3040);
        check("t3_full_again", 64'(req_ready), 64'd0);

        // ---------------- B and accept on the same edge ----------------
        req_addr = 32'h0000_5000;
        BVALID   = 1'b1;
        settle();
        check("t4_full_with_b", 64'(req_ready), 64'd0);
        step(); settle();
        check("t4_ready_cnt3", 64'(req_ready), 64'd1);
        step();
        BVALID   = 1'b0;
        req_addr = 32'h0000_6000;
        settle();
        check("t4_same_edge_addr", 64'(AWADDR), 64'h5000);
        check("t4_same_edge_cnt3", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        settle();
        check("t4_full_cnt4", 64'(req_ready), 64'd0);
        check("t4_addr6000",  64'(AWADDR), 64'h6000);
        BVALID = 1'b1;
        repeat (4) step();
        BVALID = 1'b0;
        settle();
        check("t4_drained_busy", 64'(busy), 64'd0);
        check("t4_drained_perr", 64'(protocol_err), 64'd0);

        // ---------------- unexpected B ----------------
        BVALID = 1'b1;
        step();
        BVALID = 1'b0;
        settle();
        check("t5_perr_set", 64'(protocol_err), 64'd1);
        check("t5_busy",     64'(busy), 64'd0);
        step(); settle();
        check("t5_perr_sticky", 64'(protocol_err), 64'd1);
        check("t5_no_wrap",     64'(req_ready), 64'd1);

        // ---------------- reset with AW pending, two outstanding ----------------
        req_valid = 1'b1;
        req_addr  = 32'h0000_7000;
        step();
        req_addr  = 32'h0000_7010;
        settle();
        check("t6_ready_2nd", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        AWREADY   = 1'b0;
        settle();
        check("t6_aw_pend", 64'(AWVALID), 64'd1);
        check("t6_aw_addr", 64'(AWADDR), 64'h7010);
        ARESETn = 1'b0;
        settle();
        check("t6_rst_ready",  64'(req_ready), 64'd0);
        check("t6_rst_bready", 64'(BREADY), 64'd0);
        step();
        ARESETn = 1'b1;
        settle();
        check("t6_awvalid", 64'(AWVALID), 64'd0);
        check("t6_wvalid",  64'(WVALID), 64'd0);
        check("t6_busy",    64'(busy), 64'd0);
        check("t6_ready",   64'(req_ready), 64'd1);
        check("t6_perr",    64'(protocol_err), 64'd0);
        check("t6_no_x", 64'($isunknown({req_ready, rsp_valid, rsp_err, busy, protocol_err,
                                          AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWPROT,
                                          WVALID, WDATA, WSTRB, WLAST, BREADY})), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
